// File: rtl/bcd_scan_display.sv
// Multiplexed BCD display driver: latches a multi-digit BCD count on load and
// scans it onto one shared 7-segment bus with one-hot digit enables.
module bcd_scan_display #(
  parameter int unsigned NUM_DIGITS     = 4,
  parameter int unsigned PRESCALE       = 1000,
  parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [4*NUM_DIGITS-1:0]       bcd_in,
  input  logic [NUM_DIGITS-1:0]         dp_in,
  input  logic                          load,
  input  logic                          blank_lz,
  output logic [6:0]                    seg,
  output logic                          dp,
  output logic [NUM_DIGITS-1:0]         an,
  output logic [$clog2(NUM_DIGITS)-1:0] scan_idx,
  output logic                          err
);

  localparam int unsigned IW = $clog2(NUM_DIGITS);
  localparam int unsigned CW = $clog2(PRESCALE);

  localparam logic [6:0]            SEG_OFF = {7{SEG_ACTIVE_LOW}};
  localparam logic                  DP_OFF  = SEG_ACTIVE_LOW;
  localparam logic [NUM_DIGITS-1:0] AN_OFF  = {NUM_DIGITS{SEG_ACTIVE_LOW}};

  logic [4*NUM_DIGITS-1:0] latch_q, latch_d;
  logic [NUM_DIGITS-1:0]   dpl_q, dpl_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic                    err_q, err_d;
  logic [6:0]              seg_q, seg_d;
  logic                    dp_q, dp_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;

  logic                    bad_in;
  logic                    cnt_wrap;
  logic [NUM_DIGITS-1:0]   zero_from;
  logic                    zf_run;
  logic [3:0]              sel_nib;
  logic                    sel_dp;
  logic                    sel_lz;
  logic [NUM_DIGITS-1:0]   sel_an;
  logic [6:0]              seg_hi;

  function automatic logic [6:0] seg_decode(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = 7'h40;
    endcase
    return s;
  endfunction

  // Latch, sticky error flag and scan counters
  always_comb begin
    bad_in = 1'b0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (bcd_in[4*i +: 4] > 4'd9) bad_in = 1'b1;
    end

    latch_d = latch_q;
    dpl_d   = dpl_q;
    err_d   = err_q;
    if (load) begin
      latch_d = bcd_in;
      dpl_d   = dp_in;
      if (bad_in) err_d = 1'b1;
    end

    cnt_wrap = (cnt_q == CW'(PRESCALE - 1));
    cnt_d    = cnt_wrap ? '0 : cnt_q + CW'(1);
    idx_d    = idx_q;
    if (cnt_wrap) begin
      idx_d = (idx_q == IW'(NUM_DIGITS - 1)) ? '0 : idx_q + IW'(1);
    end
  end

  // zero_from[i]: digit i and every more-significant digit are zero
  always_comb begin
    zero_from = '0;
    zf_run    = 1'b1;
    for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
      zf_run = zf_run & (latch_q[4*(NUM_DIGITS-1-k) +: 4] == 4'd0);
      zero_from[NUM_DIGITS-1-k] = zf_run;
    end
  end

  always_comb begin
    sel_nib = '0;
    sel_dp  = 1'b0;
    sel_lz  = 1'b0;
    sel_an  = '0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == IW'(i)) begin
        sel_nib   = latch_q[4*i +: 4];
        sel_dp    = dpl_q[i];
        sel_lz    = zero_from[i] && (i != 0);
        sel_an[i] = 1'b1;
      end
    end

    seg_hi = seg_decode(sel_nib);
    if (blank_lz && sel_lz) seg_hi = '0;

    // cnt == 0 is the dark slot right after a digit switch, so stale
    // segment data never shows on the newly selected digit.
    seg_d = SEG_OFF;
    dp_d  = DP_OFF;
    an_d  = AN_OFF;
    if (cnt_q != '0) begin
      seg_d = seg_hi ^ SEG_OFF;
      dp_d  = sel_dp ^ DP_OFF;
      an_d  = sel_an ^ AN_OFF;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      latch_q <= '0;
      dpl_q   <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      err_q   <= 1'b0;
      seg_q   <= SEG_OFF;
      dp_q    <= DP_OFF;
      an_q    <= AN_OFF;
    end else begin
      latch_q <= latch_d;
      dpl_q   <= dpl_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
      an_q    <= an_d;
    end
  end

  assign seg      = seg_q;
  assign dp       = dp_q;
  assign an       = an_q;
  assign scan_idx = idx_q;
  assign err      = err_q;

endmodule

// File: tb/tb_bcd_scan_display.sv
// Bench for bcd_scan_display: frame-phase reference model checked every cycle,
// plus directed scenarios with literal expectations and randomized loads.
module tb_bcd_scan_display;

  localparam int unsigned N = 4;
  localparam int unsigned P = 4;

  localparam logic [6:0] DEC [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};

  logic        clk;
  logic        rst;
  logic [15:0] bcd_in;
  logic [3:0]  dp_in;
  logic        load;
  logic        blank_lz;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic [1:0]  scan_idx;
  logic        err;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  // reference model state
  int unsigned edges;
  logic [15:0] mlatch;
  logic [3:0]  mdp;
  logic        merr;
  logic [6:0]  exp_seg;
  logic        exp_dp;
  logic [3:0]  exp_an;
  logic [1:0]  exp_idx;
  logic        exp_err;

  bcd_scan_display #(
    .NUM_DIGITS    (N),
    .PRESCALE      (P),
    .SEG_ACTIVE_LOW(1'b1)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .bcd_in  (bcd_in),
    .dp_in   (dp_in),
    .load    (load),
    .blank_lz(blank_lz),
    .seg     (seg),
    .dp      (dp),
    .an      (an),
    .scan_idx(scan_idx),
    .err     (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Output after an edge, given e edges before it, latch contents and blank_lz.
  function automatic logic [11:0] model_out(input int unsigned e, input logic [15:0] lat,
                                            input logic [3:0] dpl, input logic blz);
    int unsigned phase, d;
    logic [6:0]  s;
    logic [3:0]  a;
    phase = e % (N * P);
    d     = phase / P;
    if (phase % P == 0) return {4'hF, 1'b1, 7'h7F};
    s = DEC[lat[4*d +: 4]];
    if (blz && d != 0 && (lat >> (4 * d)) == 16'd0) s = 7'h00;
    a    = 4'hF;
    a[d] = 1'b0;
    return {a, ~dpl[d], ~s};
  endfunction

  function automatic logic has_invalid(input logic [15:0] v);
    for (int k = 0; k < 4; k++) if (v[4*k +: 4] > 4'd9) return 1'b1;
    return 1'b0;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      edges   <= 0;
      mlatch  <= '0;
      mdp     <= '0;
      merr    <= 1'b0;
      {exp_an, exp_dp, exp_seg} <= {4'hF, 1'b1, 7'h7F};
      exp_idx <= '0;
      exp_err <= 1'b0;
    end else begin
      {exp_an, exp_dp, exp_seg} <= model_out(edges, mlatch, mdp, blank_lz);
      if (load) begin
        mlatch <= bcd_in;
        mdp    <= dp_in;
      end
      merr    <= merr | (load && has_invalid(bcd_in));
      exp_err <= merr | (load && has_invalid(bcd_in));
      edges   <= edges + 1;
      exp_idx <= 2'(((edges + 1) / P) % N);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("an", 32'(an), 32'(exp_an));
      check("seg", 32'(seg), 32'(exp_seg));
      check("dp", 32'(dp), 32'(exp_dp));
      check("scan_idx", 32'(scan_idx), 32'(exp_idx));
      check("err", 32'(err), 32'(exp_err));
    end
  end

  task automatic check_reset_now(input string tag);
    check({tag, "_seg"}, 32'(seg), 32'h7F);
    check({tag, "_an"}, 32'(an), 32'hF);
    check({tag, "_dp"}, 32'(dp), 32'h1);
    check({tag, "_idx"}, 32'(scan_idx), 32'h0);
    check({tag, "_err"}, 32'(err), 32'h0);
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] d);
    bcd_in = v;
    dp_in  = d;
    load   = 1'b1;
    @(negedge clk);
    load = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_an(input logic [3:0] target, input string name);
    int unsigned n = 0;
    while (an !== target && n < 4 * N * P) begin
      @(negedge clk);
      n++;
    end
    if (an !== target) check({name, "_timeout"}, 32'(an), 32'(target));
  endtask

  task automatic async_reset_pulse(input string tag);
    #2 rst = 1'b1;
    #1 check_reset_now(tag);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int unsigned n;
    logic [15:0] v;
    int unsigned z;
    rst = 1'b0; bcd_in = '0; dp_in = '0; load = 1'b0; blank_lz = 1'b0;
    #1 rst = 1'b1;
    chk_en = 1'b1;
    #1 check_reset_now("por");
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("first_edge_dark", 32'(an), 32'hF);
    @(negedge clk);
    check("second_edge_lit", 32'(an), 32'hE);
    check("second_edge_seg", 32'(seg), 32'h40);

    // scan of 1234
    do_load(16'h1234, 4'h0);
    wait_an(4'hE, "w1234_d0");
    check("d0_is_4", 32'(seg), 32'h19);
    wait_an(4'h7, "w1234_d3");
    check("d3_is_1", 32'(seg), 32'h79);

    // reset mid-dwell
    wait_an(4'hD, "w_mid");
    async_reset_pulse("mid_dwell");

    // leading-zero suppression
    blank_lz = 1'b1;
    do_load(16'h0070, 4'h0);
    wait_an(4'h7, "lz_d3"); check("lz_d3_blank", 32'(seg), 32'h7F);
    wait_an(4'hB, "lz_d2"); check("lz_d2_blank", 32'(seg), 32'h7F);
    wait_an(4'hD, "lz_d1"); check("lz_d1_7", 32'(seg), 32'h78);
    wait_an(4'hE, "lz_d0"); check("lz_d0_0", 32'(seg), 32'h40);
    blank_lz = 1'b0;
    repeat (2) @(negedge clk);
    wait_an(4'h7, "nolz_d3"); check("nolz_d3_0", 32'(seg), 32'h40);
    wait_an(4'hB, "nolz_d2"); check("nolz_d2_0", 32'(seg), 32'h40);

    // all zero
    blank_lz = 1'b1;
    do_load(16'h0000, 4'h0);
    wait_an(4'h7, "z_d3"); check("z_d3_blank", 32'(seg), 32'h7F);
    wait_an(4'hB, "z_d2"); check("z_d2_blank", 32'(seg), 32'h7F);
    wait_an(4'hD, "z_d1"); check("z_d1_blank", 32'(seg), 32'h7F);
    wait_an(4'hE, "z_d0"); check("z_d0_0", 32'(seg), 32'h40);

    // invalid code and sticky err
    blank_lz = 1'b0;
    do_load(16'h00A5, 4'h0);
    wait_an(4'hD, "inv_d1"); check("inv_dash", 32'(seg), 32'h3F);
    check("inv_err", 32'(err), 32'h1);
    do_load(16'h0005, 4'h0);
    check("err_sticky", 32'(err), 32'h1);
    repeat (20) @(negedge clk);
    check("err_sticky_late", 32'(err), 32'h1);
    async_reset_pulse("err_clear");

    // load on the edge where the prescaler wraps
    n = 0;
    while (edges % P != P - 1 && n < 2 * P) begin
      @(negedge clk);
      n++;
    end
    check("wrap_align", 32'(edges % P), 32'(P - 1));
    bcd_in = 16'h9999; dp_in = 4'b0100; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    @(negedge clk);
    check("switch_dark", 32'(an), 32'hF);
    @(negedge clk);
    check("switch_new9", 32'(seg), 32'h10);
    wait_an(4'hB, "dp_d2"); check("dp_on_d2", 32'(dp), 32'h0);
    wait_an(4'hE, "dp_d0"); check("dp_off_d0", 32'(dp), 32'h1);
    wait_an(4'h7, "dp_d3"); check("dp_off_d3", 32'(dp), 32'h1);

    // randomized loads, decimal points and blank_lz toggling
    for (int it = 0; it < 3000; it++) begin
      @(negedge clk);
      if (it == 1500) async_reset_pulse("rand_rst");
      load = ($urandom_range(0, 7) == 0);
      z = $urandom_range(0, 4);
      for (int k = 0; k < 4; k++) begin
        v[4*k +: 4] = ($urandom_range(0, 19) == 0) ? 4'($urandom_range(10, 15))
                                                    : 4'($urandom_range(0, 9));
        if (k >= 4 - int'(z)) v[4*k +: 4] = 4'd0;
      end
      bcd_in = v;
      dp_in  = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 31) == 0) blank_lz = ~blank_lz;
    end
    load = 1'b0;
    repeat (2) @(negedge clk);

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

endmodule
